// File: rtl/sti_byte_packer.sv
// Rebuilds 8-bit bytes from the STI serial stream and writes them to a byte memory port.
// Optional build macro STI_PACK_PARITY_EN adds the registered even-parity output pk_par.
module sti_byte_packer #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              si_data,
  input  logic              si_valid,
  input  logic              cfg_msb,
  output logic [7:0]        pk_data,
  output logic              pk_we,
  output logic [ADDR_W-1:0] pk_addr,
  output logic              frame_done,
  output logic              frame_err,
  output logic [ADDR_W-1:0] frame_bytes
`ifdef STI_PACK_PARITY_EN
  ,
  output logic              pk_par
`endif
);

  typedef enum logic [1:0] {StIdle, StRecv, StFlush} state_e;

  state_e              state_q, state_d;
  logic [7:0]          shreg_q, shreg_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic                msb_q, msb_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   fcnt_q, fcnt_d;

  logic [7:0]          pk_data_q, pk_data_d;
  logic                pk_we_q, pk_we_d;
  logic [ADDR_W-1:0]   pk_addr_q, pk_addr_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   bytes_q, bytes_d;

  logic [7:0]          byte_next;
  logic [7:0]          byte_fresh;
  logic [7:0]          byte_padded;
  logic [3:0]          pad_sh;

  // MSB-first shifts left so bit 1 lands in [7]; LSB-first shifts right so it lands in [0].
  function automatic logic [7:0] shift_in(input logic [7:0] base, input logic b,
                                          input logic msb);
    return msb ? {base[6:0], b} : {b, base[7:1]};
  endfunction

  always_comb begin
    byte_next  = shift_in(shreg_q, si_data, msb_q);
    byte_fresh = shift_in(8'h00, si_data, cfg_msb);
    pad_sh     = 4'd8 - {1'b0, bit_cnt_q};
    // Partial byte is justified toward the early side; zeros fill the late side.
    byte_padded = msb_q ? (shreg_q << pad_sh) : (shreg_q >> pad_sh);
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    msb_d     = msb_q;
    ptr_d     = ptr_q;
    fcnt_d    = fcnt_q;
    pk_data_d = 8'h00;
    pk_we_d   = 1'b0;
    pk_addr_d = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    bytes_d   = '0;

    unique case (state_q)
      StIdle: begin
        if (si_valid) begin
          msb_d     = cfg_msb;
          shreg_d   = byte_fresh;
          bit_cnt_d = 3'd1;
          fcnt_d    = '0;
          state_d   = StRecv;
        end
      end
      StRecv: begin
        if (si_valid) begin
          shreg_d   = byte_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            pk_we_d   = 1'b1;
            pk_data_d = byte_next;
            pk_addr_d = ptr_q;
            ptr_d     = ptr_q + ADDR_W'(1);
            fcnt_d    = fcnt_q + ADDR_W'(1);
          end
        end else if (bit_cnt_q == 3'd0) begin
          done_d  = 1'b1;
          bytes_d = fcnt_q;
          state_d = StIdle;
        end else begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        pk_we_d   = 1'b1;
        pk_data_d = byte_padded;
        pk_addr_d = ptr_q;
        ptr_d     = ptr_q + ADDR_W'(1);
        done_d    = 1'b1;
        err_d     = 1'b1;
        bytes_d   = fcnt_q + ADDR_W'(1);
        bit_cnt_d = 3'd0;
        state_d   = StIdle;
        // A bit arriving here opens the next frame immediately.
        if (si_valid) begin
          msb_d     = cfg_msb;
          shreg_d   = byte_fresh;
          bit_cnt_d = 3'd1;
          fcnt_d    = '0;
          state_d   = StRecv;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      shreg_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      msb_q     <= 1'b0;
      ptr_q     <= '0;
      fcnt_q    <= '0;
      pk_data_q <= 8'h00;
      pk_we_q   <= 1'b0;
      pk_addr_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      bytes_q   <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      msb_q     <= msb_d;
      ptr_q     <= ptr_d;
      fcnt_q    <= fcnt_d;
      pk_data_q <= pk_data_d;
      pk_we_q   <= pk_we_d;
      pk_addr_q <= pk_addr_d;
      done_q    <= done_d;
      err_q     <= err_d;
      bytes_q   <= bytes_d;
    end
  end

  assign pk_data     = pk_data_q;
  assign pk_we       = pk_we_q;
  assign pk_addr     = pk_addr_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign frame_bytes = bytes_q;

`ifdef STI_PACK_PARITY_EN
  logic par_q;

  // pk_data_d is zero whenever no write is issued, so parity is zero then too.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^pk_data_d;
    end
  end

  assign pk_par = par_q;
`endif

endmodule

// File: tb/tb_sti_byte_packer.sv
// Directed bench for sti_byte_packer: byte assembly, padding, pointer wrap, reset mid-frame.
// Parity checks are compiled in when STI_PACK_PARITY_EN is defined.
module tb_sti_byte_packer;

  logic       clk;
  logic       reset;
  logic       si_data;
  logic       si_valid;
  logic       cfg_msb;
  logic [7:0] pk_data;
  logic       pk_we;
  logic [7:0] pk_addr;
  logic       frame_done;
  logic       frame_err;
  logic [7:0] frame_bytes;
  logic [7:0] pk_data2;
  logic       pk_we2;
  logic [1:0] pk_addr2;
  logic       frame_done2;
  logic       frame_err2;
  logic [1:0] frame_bytes2;
`ifdef STI_PACK_PARITY_EN
  logic       pk_par;
  logic       pk_par2;
`endif

  sti_byte_packer #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .si_data(si_data), .si_valid(si_valid), .cfg_msb(cfg_msb),
    .pk_data(pk_data), .pk_we(pk_we), .pk_addr(pk_addr), .frame_done(frame_done),
    .frame_err(frame_err), .frame_bytes(frame_bytes)
`ifdef STI_PACK_PARITY_EN
    , .pk_par(pk_par)
`endif
  );

  sti_byte_packer #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .si_data(si_data), .si_valid(si_valid), .cfg_msb(cfg_msb),
    .pk_data(pk_data2), .pk_we(pk_we2), .pk_addr(pk_addr2), .frame_done(frame_done2),
    .frame_err(frame_err2), .frame_bytes(frame_bytes2)
`ifdef STI_PACK_PARITY_EN
    , .pk_par(pk_par2)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc;

  logic [7:0] wq_data[$];
  logic [7:0] wq_addr[$];
  int         wq_cyc[$];
  logic       wq_par[$];
  logic       dq_err[$];
  logic [7:0] dq_bytes[$];
  int         dq_cyc[$];
  logic [1:0] a2q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pk_we === 1'b1) begin
      wq_data.push_back(pk_data);
      wq_addr.push_back(pk_addr);
      wq_cyc.push_back(cyc);
`ifdef STI_PACK_PARITY_EN
      wq_par.push_back(pk_par);
`else
      wq_par.push_back(1'b0);
`endif
    end
    if (frame_done === 1'b1) begin
      dq_err.push_back(frame_err);
      dq_bytes.push_back(frame_bytes);
      dq_cyc.push_back(cyc);
    end
    if (pk_we2 === 1'b1) a2q.push_back(pk_addr2);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wq_data.delete(); wq_addr.delete(); wq_cyc.delete(); wq_par.delete();
    dq_err.delete(); dq_bytes.delete(); dq_cyc.delete(); a2q.delete();
  endtask

  task automatic idle(input int n);
    si_valid = 1'b0;
    si_data  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    si_valid = 1'b0;
    si_data  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Sends bits[n-1] first; leaves si_valid low afterwards.
  task automatic send(input logic [31:0] bits, input int n, input logic msb);
    for (int i = 0; i < n; i++) begin
      si_valid = 1'b1;
      si_data  = bits[n-1-i];
      cfg_msb  = msb;
      @(posedge clk);
      #1;
    end
    si_valid = 1'b0;
    si_data  = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic expect_wr(input string tag, input logic [7:0] d, input logic [7:0] a,
                           input int c, input logic par);
    chk({tag, "_wr_present"}, 32'(wq_data.size() != 0), 32'd1);
    if (wq_data.size() != 0) begin
      chk({tag, "_data"}, 32'(wq_data.pop_front()), 32'(d));
      chk({tag, "_addr"}, 32'(wq_addr.pop_front()), 32'(a));
      if (c >= 0) chk({tag, "_wr_cycle"}, 32'(wq_cyc.pop_front()), 32'(c));
      else void'(wq_cyc.pop_front());
`ifdef STI_PACK_PARITY_EN
      chk({tag, "_par"}, 32'(wq_par.pop_front()), 32'(par));
`else
      if (par === 1'bx) $display("note: parity not built");
      void'(wq_par.pop_front());
`endif
    end
  endtask

  task automatic expect_done(input string tag, input logic err, input logic [7:0] nbytes,
                             input int c);
    chk({tag, "_done_present"}, 32'(dq_err.size() != 0), 32'd1);
    if (dq_err.size() != 0) begin
      chk({tag, "_err"}, 32'(dq_err.pop_front()), 32'(err));
      chk({tag, "_bytes"}, 32'(dq_bytes.pop_front()), 32'(nbytes));
      if (c >= 0) chk({tag, "_done_cycle"}, 32'(dq_cyc.pop_front()), 32'(c));
      else void'(dq_cyc.pop_front());
    end
  endtask

  initial begin
    int l;
    reset    = 1'b1;
    si_valid = 1'b0;
    si_data  = 1'b0;
    cfg_msb  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pk_we", 32'(pk_we), 32'd0);
    chk("rst_pk_data", 32'(pk_data), 32'd0);
    chk("rst_pk_addr", 32'(pk_addr), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_frame_bytes", 32'(frame_bytes), 32'd0);
`ifdef STI_PACK_PARITY_EN
    chk("rst_pk_par", 32'(pk_par), 32'd0);
`endif
    reset = 1'b0;
    clr();

    // 8-bit frame, MSB-first: bits 1,0,1,0,0,0,1,1.
    send(32'hA3, 8, 1'b1);
    l = last_cyc;
    idle(3);
    expect_wr("msb8", 8'hA3, 8'h00, l, 1'b0);
    expect_done("msb8", 1'b0, 8'd1, l + 1);

    // Same bits, LSB-first.
    do_reset(); clr();
    send(32'hA3, 8, 1'b0);
    idle(3);
    expect_wr("lsb8", 8'hC5, 8'h00, -1, 1'b0);
    expect_done("lsb8", 1'b0, 8'd1, -1);

    // 16-bit BEEF then 8-bit 5A after a single-cycle gap.
    do_reset(); clr();
    send(32'hBEEF, 16, 1'b1);
    idle(1);
    send(32'h5A, 8, 1'b1);
    l = last_cyc;
    idle(3);
    expect_wr("be", 8'hBE, 8'h00, -1, 1'b0);
    expect_wr("ef", 8'hEF, 8'h01, -1, 1'b1);
    expect_done("beef", 1'b0, 8'd2, -1);
    expect_wr("5a", 8'h5A, 8'h02, l, 1'b0);
    expect_done("5a", 1'b0, 8'd1, l + 1);

    // 5-bit frame 1,1,0,1,1 padded, both orders.
    do_reset(); clr();
    send(32'h1B, 5, 1'b1);
    l = last_cyc;
    idle(4);
    expect_wr("pad_msb", 8'hD8, 8'h00, l + 2, 1'b0);
    expect_done("pad_msb", 1'b1, 8'd1, l + 2);
    do_reset(); clr();
    send(32'h1B, 5, 1'b0);
    idle(4);
    expect_wr("pad_lsb", 8'h1B, 8'h00, -1, 1'b0);
    expect_done("pad_lsb", 1'b1, 8'd1, -1);

    // 3-bit LSB-first frame, next frame's first bit arrives during FLUSH with MSB-first.
    do_reset(); clr();
    send(32'h5, 3, 1'b0);
    idle(1);
    send(32'h5A, 8, 1'b1);
    idle(3);
    expect_wr("flush_a", 8'h05, 8'h00, -1, 1'b0);
    expect_done("flush_a", 1'b1, 8'd1, -1);
    expect_wr("flush_b", 8'h5A, 8'h01, -1, 1'b0);
    expect_done("flush_b", 1'b0, 8'd1, -1);

    // Pointer wrap on the 2-bit-address instance.
    do_reset(); clr();
    for (int i = 0; i < 5; i++) begin
      send(32'hA3, 8, 1'b1);
      idle(1);
    end
    idle(2);
    chk("wrap_count", 32'(a2q.size()), 32'd5);
    if (a2q.size() == 5) begin
      chk("wrap_a0", 32'(a2q[0]), 32'd0);
      chk("wrap_a1", 32'(a2q[1]), 32'd1);
      chk("wrap_a2", 32'(a2q[2]), 32'd2);
      chk("wrap_a3", 32'(a2q[3]), 32'd3);
      chk("wrap_a4", 32'(a2q[4]), 32'd0);
    end

    // Reset after 5 bits of a 16-bit frame, then a fresh 3C frame.
    do_reset(); clr();
    send(32'h17, 5, 1'b1);
    chk("midrst_no_wr_before", 32'(wq_data.size()), 32'd0);
    do_reset();
    chk("midrst_no_wr", 32'(wq_data.size()), 32'd0);
    chk("midrst_no_done", 32'(dq_err.size()), 32'd0);
    send(32'h3C, 8, 1'b1);
    idle(3);
    expect_wr("midrst_3c", 8'h3C, 8'h00, -1, 1'b0);
    expect_done("midrst_3c", 1'b0, 8'd1, -1);

    chk("no_extra_wr", 32'(wq_data.size()), 32'd0);
    chk("no_extra_done", 32'(dq_err.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
